// File: rtl/hamming_pkg.sv
// Shared FSM type and elaboration-time helpers for the serial Hamming decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CORRECT = 2'd2
  } state_e;

  // Parity bit count for the three perfect-code payload widths; 0 marks an illegal width.
  function automatic int par_w_of(input int data_w);
    int r;
    case (data_w)
      4:       r = 3;
      11:      r = 4;
      26:      r = 5;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position (1-based) that carries payload bit k.
  function automatic int data_pos(input int k);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 1; p < 64; p++) begin
      if (!is_pow2(p)) begin
        if ((n == k) && (r == 0)) r = p;
        n++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial position counter with syndrome and overall-parity accumulation.
// Accepting position 1 restarts the sums, so a finished frame's syndrome holds until the next frame.
module hamming_syndrome_acc
  import hamming_pkg::*;
#(
  parameter int PAR_W   = 3,
  parameter int CODE_W  = 7,
  parameter int FRAME_W = 7,
  parameter int CNT_W   = PAR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic             restart_i,
  input  logic             clr_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] pos_o,
  output logic             last_o,
  output logic [PAR_W-1:0] syn_o,
  output logic             par_o
);

  localparam logic [CNT_W-1:0] CODE_POS  = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] FRAME_POS = CNT_W'(FRAME_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAR_W-1:0] syn_q, syn_d;
  logic             par_q, par_d;
  logic             first;

  // cnt_q counts bits already taken in this frame; zero means the next bit is position 1.
  assign first  = restart_i || (cnt_q == '0);
  assign pos_o  = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign last_o = (pos_o == FRAME_POS);
  assign syn_o  = syn_q;
  assign par_o  = par_q;

  always_comb begin
    cnt_d = cnt_q;
    syn_d = syn_q;
    par_d = par_q;
    if (acc_i) begin
      cnt_d = last_o ? '0 : pos_o;
      syn_d = first ? '0 : syn_q;
      par_d = first ? 1'b0 : par_q;
      if (bit_i) begin
        par_d = ~par_d;
        // The trailing overall-parity bit sits beyond CODE_W and never enters the syndrome.
        if (pos_o <= CODE_POS) syn_d = syn_d ^ pos_o[PAR_W-1:0];
      end
    end else if (clr_i) begin
      cnt_d = '0;
      syn_d = '0;
      par_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      syn_q <= '0;
      par_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      syn_q <= syn_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial Hamming decoder: one codeword bit per ena strobe, single-error correction one clock after the last bit.
// Define HAMMING_SECDED_EN to append an overall even-parity bit and flag double errors.
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int PAR_W  = par_w_of(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              bit_in,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              err_corrected,
  output logic              err_uncorrectable,
  output logic [PAR_W-1:0]  err_pos,
  output logic              busy
);

  localparam int CNT_W = PAR_W + 1;
`ifdef HAMMING_SECDED_EN
  localparam int FRAME_W = CODE_W + 1;
`else
  localparam int FRAME_W = CODE_W;
`endif

  if (PAR_W == 0) begin : g_bad_data_w
    $error("hamming_serial_decoder: DATA_W must be 4, 11 or 26");
  end

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              fs_pend_q, fs_pend_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              corr_q, corr_d;
  logic              unc_q, unc_d;
  logic [PAR_W-1:0]  epos_q, epos_d;

  logic              resync, accept, restart, clr;
  logic [CNT_W-1:0]  pos;
  logic              last;
  logic [PAR_W-1:0]  syn;
  logic              par;
  logic [CODE_W-1:0] wmask, fixed;
  logic [DATA_W-1:0] data_fix;
  logic              do_fix, dec_corr, dec_unc;
  logic [PAR_W-1:0]  dec_pos;

  // A frame_start seen during CORRECT is replayed on the following cycle.
  assign resync  = frame_start || fs_pend_q;
  assign accept  = ena && (state_q != CORRECT);
  assign restart = accept && resync;
  assign clr     = !ena && resync && (state_q != CORRECT);

  hamming_syndrome_acc #(
    .PAR_W   (PAR_W),
    .CODE_W  (CODE_W),
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_i     (accept),
    .restart_i (restart),
    .clr_i     (clr),
    .bit_i     (bit_in),
    .pos_o     (pos),
    .last_o    (last),
    .syn_o     (syn),
    .par_o     (par)
  );

  // The parity position shifts past the buffer, so its mask is empty.
  assign wmask = CODE_W'(1) << (pos - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    fs_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = last ? CORRECT : SHIFT;
      end
      SHIFT: begin
        if (accept) begin
          if (last) state_d = CORRECT;
        end else if (clr) begin
          state_d = IDLE;
        end
      end
      CORRECT: begin
        state_d   = IDLE;
        fs_pend_d = frame_start;
      end
      default: state_d = IDLE;
    endcase
    if (accept) buf_d = bit_in ? (buf_q | wmask) : (buf_q & ~wmask);
    busy_d = (state_d == CORRECT);
  end

  always_comb begin
    do_fix   = 1'b0;
    dec_corr = 1'b0;
    dec_unc  = 1'b0;
    dec_pos  = '0;
`ifdef HAMMING_SECDED_EN
    if (syn != '0) begin
      if (par) begin
        do_fix   = 1'b1;
        dec_corr = 1'b1;
        dec_pos  = syn;
      end else begin
        dec_unc = 1'b1;
      end
    end else if (par) begin
      dec_corr = 1'b1;
    end
`else
    if (syn != '0) begin
      do_fix   = 1'b1;
      dec_corr = 1'b1;
      dec_pos  = syn;
    end
`endif
  end

`ifndef HAMMING_SECDED_EN
  logic unused_par;
  assign unused_par = par;
`endif

  assign fixed = buf_q ^ (do_fix ? (CODE_W'(1) << (syn - PAR_W'(1))) : '0);

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    assign data_fix[k] = fixed[data_pos(k) - 1];
  end

  always_comb begin
    valid_d = (state_q == CORRECT);
    data_d  = valid_d ? data_fix : data_q;
    corr_d  = valid_d ? dec_corr : corr_q;
    unc_d   = valid_d ? dec_unc  : unc_q;
    epos_d  = valid_d ? dec_pos  : epos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      fs_pend_q <= 1'b0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
      epos_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      fs_pend_q <= fs_pend_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      corr_q    <= corr_d;
      unc_q     <= unc_d;
      epos_q    <= epos_d;
    end
  end

  assign data_out          = data_q;
  assign valid_out         = valid_q;
  assign err_corrected     = corr_q;
  assign err_uncorrectable = unc_q;
  assign err_pos           = epos_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Bench for hamming_serial_decoder at DATA_W 4/11/26 against an encoder-based reference model.
`timescale 1ns/1ps
module tb_hamming_serial_decoder;

`ifdef HAMMING_SECDED_EN
  localparam int SECDED = 1;
`else
  localparam int SECDED = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ena_v, bit_v, fs_v;
  wire  [3:0]  d4;
  wire  [10:0] d11;
  wire  [25:0] d26;
  wire  [2:0]  p4;
  wire  [3:0]  p11;
  wire  [4:0]  p26;
  wire  [2:0]  valid_w, corr_w, unc_w, busy_w;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt[3] = '{0, 0, 0};

  hamming_serial_decoder #(.DATA_W(4)) u_dec4 (
    .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .bit_in(bit_v[0]), .frame_start(fs_v[0]),
    .data_out(d4), .valid_out(valid_w[0]), .err_corrected(corr_w[0]),
    .err_uncorrectable(unc_w[0]), .err_pos(p4), .busy(busy_w[0]));

  hamming_serial_decoder #(.DATA_W(11)) u_dec11 (
    .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .bit_in(bit_v[1]), .frame_start(fs_v[1]),
    .data_out(d11), .valid_out(valid_w[1]), .err_corrected(corr_w[1]),
    .err_uncorrectable(unc_w[1]), .err_pos(p11), .busy(busy_w[1]));

  hamming_serial_decoder #(.DATA_W(26)) u_dec26 (
    .clk(clk), .rst_n(rst_n), .ena(ena_v[2]), .bit_in(bit_v[2]), .frame_start(fs_v[2]),
    .data_out(d26), .valid_out(valid_w[2]), .err_corrected(corr_w[2]),
    .err_uncorrectable(unc_w[2]), .err_pos(p26), .busy(busy_w[2]));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (valid_w[i]) vcnt[i] <= vcnt[i] + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cw(input int i);
    return (i == 0) ? 7 : (i == 1) ? 15 : 31;
  endfunction

  function automatic int dw(input int i);
    return (i == 0) ? 4 : (i == 1) ? 11 : 26;
  endfunction

  function automatic int fw(input int i);
    return cw(i) + SECDED;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    case (i)
      0:       return {28'd0, d4};
      1:       return {21'd0, d11};
      default: return {6'd0, d26};
    endcase
  endfunction

  function automatic logic [31:0] get_pos(input int i);
    case (i)
      0:       return {29'd0, p4};
      1:       return {28'd0, p11};
      default: return {27'd0, p26};
    endcase
  endfunction

  // Reference encoder: bit p-1 of the result is codeword position p.
  function automatic logic [31:0] encode(input int i, input logic [25:0] d);
    logic [31:0] c;
    int k;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p <= cw(i); p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= cw(i); p = p * 2) begin
      x = 1'b0;
      for (int q = 1; q <= cw(i); q++) if ((q != p) && ((q & p) != 0)) x = x ^ c[q-1];
      c[p-1] = x;
    end
    if (SECDED != 0) begin
      x = 1'b0;
      for (int q = 1; q <= cw(i); q++) x = x ^ c[q-1];
      c[cw(i)] = x;
    end
    return c;
  endfunction

  function automatic logic [25:0] extract(input int i, input logic [31:0] c);
    logic [25:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= cw(i); p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic drive_bit(input int i, input logic b, input logic fs);
    @(negedge clk);
    ena_v[i] = 1'b1;
    bit_v[i] = b;
    fs_v[i]  = fs;
  endtask

  task automatic idle(input int i, input logic fs);
    @(negedge clk);
    ena_v[i] = 1'b0;
    bit_v[i] = 1'($urandom);
    fs_v[i]  = fs;
  endtask

  task automatic send_frame(input int i, input logic [31:0] fr, input logic fs_first,
                            input int gap_pct);
    for (int p = 1; p <= fw(i); p++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(i, 1'b0);
      drive_bit(i, fr[p-1], fs_first && (p == 1));
    end
  endtask

  // Called right after the last bit is driven: result must appear exactly one clock later.
  task automatic expect_frame(input int i, input string tag, input logic [25:0] ed,
                              input logic ec, input logic eu, input int ep, input logic junk);
    @(negedge clk);
    ena_v[i] = junk;
    bit_v[i] = junk ? 1'($urandom) : 1'b0;
    fs_v[i]  = junk;
    check_val({tag, ".early_valid"}, {31'd0, valid_w[i]}, 32'd0);
    check_val({tag, ".busy"}, {31'd0, busy_w[i]}, 32'd1);
    @(negedge clk);
    ena_v[i] = 1'b0;
    fs_v[i]  = 1'b0;
    check_val({tag, ".valid"}, {31'd0, valid_w[i]}, 32'd1);
    check_val({tag, ".data"}, get_data(i), {6'd0, ed});
    check_val({tag, ".corr"}, {31'd0, corr_w[i]}, {31'd0, ec});
    check_val({tag, ".unc"}, {31'd0, unc_w[i]}, {31'd0, eu});
    check_val({tag, ".pos"}, get_pos(i), ep);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".data"}, get_data(0), 32'd0);
    check_val({tag, ".valid"}, {31'd0, valid_w[0]}, 32'd0);
    check_val({tag, ".corr"}, {31'd0, corr_w[0]}, 32'd0);
    check_val({tag, ".unc"}, {31'd0, unc_w[0]}, 32'd0);
    check_val({tag, ".pos"}, get_pos(0), 32'd0);
    check_val({tag, ".busy"}, {31'd0, busy_w[0]}, 32'd0);
  endtask

  // One frame of random payload with up to two flipped positions (0 = no flip).
  task automatic run_frame(input int i, input int e1, input int e2, input string tag);
    logic [25:0] d;
    logic [31:0] r;
    int ep;
    d = 26'($urandom) & ((26'd1 << dw(i)) - 26'd1);
    r = encode(i, d);
    if (e1 != 0) r[e1-1] = ~r[e1-1];
    if (e2 != 0) r[e2-1] = ~r[e2-1];
    send_frame(i, r, 1'($urandom), int'($urandom_range(30)));
    if ((e1 != 0) && (e2 != 0)) begin
      expect_frame(i, tag, extract(i, r), 1'b0, 1'b1, 0, 1'($urandom));
    end else if (e1 != 0) begin
      ep = (e1 <= cw(i)) ? e1 : 0;
      expect_frame(i, tag, d, 1'b1, 1'b0, ep, 1'($urandom));
    end else begin
      expect_frame(i, tag, d, 1'b0, 1'b0, 0, 1'($urandom));
    end
  endtask

  initial begin
    int v0;
    int e1, e2, cls;
    rst_n = 1'b0;
    ena_v = '0;
    bit_v = '0;
    fs_v  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(0, 32'h55, 1'b0, 0);
    expect_frame(0, "clean", 26'b1011, 1'b0, 1'b0, 0, 1'b0);

    send_frame(0, 32'h75, 1'b0, 0);
    expect_frame(0, "single6", 26'b1011, 1'b1, 1'b0, 6, 1'b1);

    // Gapped frame, then an abandoned partial frame and a resynced clean frame.
    send_frame(0, 32'h55, 1'b0, 50);
    expect_frame(0, "gapped", 26'b1011, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    v0 = vcnt[0];
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b0, 1'b0);
    send_frame(0, 32'h55, 1'b1, 0);
    expect_frame(0, "resync", 26'b1011, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check_val("resync.one_valid", vcnt[0] - v0, 32'd1);

    // Partial frame dropped by frame_start with ena low.
    drive_bit(0, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    idle(0, 1'b1);
    send_frame(0, 32'h75, 1'b0, 20);
    expect_frame(0, "fs_idle", 26'b1011, 1'b1, 1'b0, 6, 1'b0);

    // Reset in the middle of a frame.
    for (int p = 0; p < 4; p++) drive_bit(0, 1'(p % 2 == 0), 1'b0);
    idle(0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    v0 = vcnt[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("midreset.no_valid", vcnt[0] - v0, 32'd0);
    send_frame(0, 32'h75, 1'b0, 10);
    expect_frame(0, "after_reset", 26'b1011, 1'b1, 1'b0, 6, 1'b0);

`ifdef HAMMING_SECDED_EN
    send_frame(0, 32'h47, 1'b0, 0);
    expect_frame(0, "double", 26'b1001, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 20; n++) begin
        cls = int'($urandom_range(1 + SECDED));
        e1  = 0;
        e2  = 0;
        if (cls >= 1) e1 = int'($urandom_range(fw(i), 1));
        if (cls == 2) begin
          e2 = int'($urandom_range(fw(i), 1));
          while (e2 == e1) e2 = int'($urandom_range(fw(i), 1));
        end
        run_frame(i, e1, e2, $sformatf("rand.w%0d.%0d", dw(i), n));
      end
    end

    for (int i = 1; i < 3; i++) begin
      for (int p = 1; p <= fw(i); p++) run_frame(i, p, 0, $sformatf("sweep.w%0d.p%0d", dw(i), p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
